// File: rtl/alu_bist_sequencer.sv
// alu_bist_sequencer: built-in self-test initiator for the RV32I execute path.
// It generates LFSR operand pairs and walks each pair through the R-type op table.
// Each vector is held for a settle window, and then the ALU result is compared
// against an internal golden model. A pass/fail summary is kept.
// Optional build macro BIST_BRANCH_CHECK_EN adds BEQ..BGEU (indices 10..15).
// Those ops are checked on Branch_Enable instead of ALUOut.
module alu_bist_sequencer #(
    parameter int          NUM_ITER      = 16,
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [31:0] LFSR_SEED     = 32'hACE1_2024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [3:0]  FuncCode,
    output logic [6:0]  Opcode,
    input  logic [31:0] ALUOut,
    input  logic        Branch_Enable,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] fail_count,
    output logic [3:0]  first_fail_op,
    output logic        err_pulse
);

    localparam logic [31:0] LFSR_MASK   = 32'h8020_0003;
    localparam logic [6:0]  OPC_R       = 7'b0110011;
    localparam logic [15:0] LAST_ITER   = 16'(NUM_ITER - 1);
    localparam logic [15:0] LAST_SETTLE = 16'(SETTLE_CYCLES - 1);
`ifdef BIST_BRANCH_CHECK_EN
    localparam logic [6:0]  OPC_BR      = 7'b1100011;
    localparam logic [3:0]  LAST_OP     = 4'd15;
`else
    localparam logic [3:0]  LAST_OP     = 4'd9;
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_DRIVE  = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // One Galois step of the operand generator.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_MASK : 32'h0000_0000);
    endfunction

    // Op table: {Opcode, FuncCode} for a given op index.
    function automatic logic [10:0] op_fields(input logic [3:0] op);
        logic [10:0] f;
        case (op)
            4'd0:    f = {OPC_R, 4'b0000};
            4'd1:    f = {OPC_R, 4'b1000};
            4'd2:    f = {OPC_R, 4'b0001};
            4'd3:    f = {OPC_R, 4'b0010};
            4'd4:    f = {OPC_R, 4'b0011};
            4'd5:    f = {OPC_R, 4'b0100};
            4'd6:    f = {OPC_R, 4'b0101};
            4'd7:    f = {OPC_R, 4'b1101};
            4'd8:    f = {OPC_R, 4'b0110};
            4'd9:    f = {OPC_R, 4'b0111};
`ifdef BIST_BRANCH_CHECK_EN
            4'd10:   f = {OPC_BR, 4'b0000};
            4'd11:   f = {OPC_BR, 4'b0001};
            4'd12:   f = {OPC_BR, 4'b0100};
            4'd13:   f = {OPC_BR, 4'b0101};
            4'd14:   f = {OPC_BR, 4'b0110};
            4'd15:   f = {OPC_BR, 4'b0111};
`endif
            default: f = {OPC_R, 4'b0000};
        endcase
        return f;
    endfunction

    // Golden R-type result for op index 0..9.
    function automatic logic [31:0] golden_result(input logic [3:0] op,
                                                  input logic [31:0] a,
                                                  input logic [31:0] b);
        logic [31:0] r;
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a << b[4:0];
            4'd3:    r = {31'd0, ($signed(a) < $signed(b))};
            4'd4:    r = {31'd0, (a < b)};
            4'd5:    r = a ^ b;
            4'd6:    r = a >> b[4:0];
            4'd7:    r = $signed(a) >>> b[4:0];
            4'd8:    r = a | b;
            4'd9:    r = a & b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

`ifdef BIST_BRANCH_CHECK_EN
    // Golden branch condition for op index 10..15.
    function automatic logic branch_cond(input logic [3:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
        logic c;
        case (op)
            4'd10:   c = (a == b);
            4'd11:   c = (a != b);
            4'd12:   c = ($signed(a) < $signed(b));
            4'd13:   c = ($signed(a) >= $signed(b));
            4'd14:   c = (a < b);
            4'd15:   c = (a >= b);
            default: c = 1'b0;
        endcase
        return c;
    endfunction
`endif

    state_t      state_r, state_n;
    logic [31:0] lfsr_r, lfsr_n;
    logic [31:0] a_r, a_n, b_r, b_n;
    logic [3:0]  func_r, func_n;
    logic [6:0]  opc_r, opc_n;
    logic [3:0]  op_r, op_n;
    logic [15:0] iter_r, iter_n;
    logic [15:0] settle_r, settle_n;
    logic        busy_r, busy_n, done_r, done_n, pass_r, pass_n, err_r, err_n;
    logic [15:0] fail_cnt_r, fail_cnt_n;
    logic [3:0]  ffo_r, ffo_n;
    logic        mismatch_s;
    logic [10:0] next_fields_s;

`ifdef BIST_BRANCH_CHECK_EN
    // Branch ops are judged on the flag, R-type ops on the result word.
    always_comb begin
        mismatch_s = 1'b0;
        if (op_r >= 4'd10) begin
            mismatch_s = (Branch_Enable != branch_cond(op_r, a_r, b_r));
        end else begin
            mismatch_s = (ALUOut != golden_result(op_r, a_r, b_r));
        end
    end
`else
    logic unused_branch_s;
    assign unused_branch_s = Branch_Enable;

    // Only the result word is judged when branch checking is not built in.
    always_comb begin
        mismatch_s = (ALUOut != golden_result(op_r, a_r, b_r));
    end
`endif

    assign next_fields_s = op_fields(op_r + 4'd1);

    // Next-state and next-output logic of the test sequencer.
    always_comb begin
        state_n    = state_r;
        lfsr_n     = lfsr_r;
        a_n        = a_r;
        b_n        = b_r;
        func_n     = func_r;
        opc_n      = opc_r;
        op_n       = op_r;
        iter_n     = iter_r;
        settle_n   = settle_r;
        busy_n     = busy_r;
        done_n     = done_r;
        pass_n     = pass_r;
        fail_cnt_n = fail_cnt_r;
        ffo_n      = ffo_r;
        err_n      = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                opc_n  = 7'd0;
                func_n = 4'd0;
                if (start) begin
                    state_n    = ST_LOAD_A;
                    lfsr_n     = LFSR_SEED;
                    busy_n     = 1'b1;
                    done_n     = 1'b0;
                    pass_n     = 1'b0;
                    fail_cnt_n = 16'd0;
                    ffo_n      = 4'hF;
                    iter_n     = 16'd0;
                    op_n       = 4'd0;
                end else begin
                    state_n = state_r;
                end
            end
            ST_LOAD_A: begin
                a_n     = lfsr_r;
                lfsr_n  = lfsr_step(lfsr_r);
                state_n = ST_LOAD_B;
            end
            ST_LOAD_B: begin
                b_n             = lfsr_r;
                lfsr_n          = lfsr_step(lfsr_r);
                op_n            = 4'd0;
                settle_n        = 16'd0;
                {opc_n, func_n} = op_fields(4'd0);
                state_n         = ST_DRIVE;
            end
            ST_DRIVE: begin
                if (settle_r == LAST_SETTLE) begin
                    state_n = ST_CHECK;
                end else begin
                    settle_n = settle_r + 16'd1;
                end
            end
            ST_CHECK: begin
                if (mismatch_s) begin
                    err_n = 1'b1;
                    if (fail_cnt_r != 16'hFFFF) begin
                        fail_cnt_n = fail_cnt_r + 16'd1;
                    end else begin
                        fail_cnt_n = fail_cnt_r;
                    end
                    if (ffo_r == 4'hF) begin
                        ffo_n = op_r;
                    end else begin
                        ffo_n = ffo_r;
                    end
                end else begin
                    err_n = 1'b0;
                end
                if (op_r != LAST_OP) begin
                    op_n            = op_r + 4'd1;
                    settle_n        = 16'd0;
                    {opc_n, func_n} = next_fields_s;
                    state_n         = ST_DRIVE;
                end else if (iter_r != LAST_ITER) begin
                    iter_n  = iter_r + 16'd1;
                    opc_n   = 7'd0;
                    func_n  = 4'd0;
                    state_n = ST_LOAD_A;
                end else begin
                    opc_n   = 7'd0;
                    func_n  = 4'd0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    pass_n  = (fail_cnt_n == 16'd0);
                    state_n = ST_DONE;
                end
            end
            default: begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
                opc_n   = 7'd0;
                func_n  = 4'd0;
            end
        endcase
    end

    // State and output registers; reset aborts any run back to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            lfsr_r     <= LFSR_SEED;
            a_r        <= 32'd0;
            b_r        <= 32'd0;
            func_r     <= 4'd0;
            opc_r      <= 7'd0;
            op_r       <= 4'd0;
            iter_r     <= 16'd0;
            settle_r   <= 16'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            fail_cnt_r <= 16'd0;
            ffo_r      <= 4'hF;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_n;
            lfsr_r     <= lfsr_n;
            a_r        <= a_n;
            b_r        <= b_n;
            func_r     <= func_n;
            opc_r      <= opc_n;
            op_r       <= op_n;
            iter_r     <= iter_n;
            settle_r   <= settle_n;
            busy_r     <= busy_n;
            done_r     <= done_n;
            pass_r     <= pass_n;
            fail_cnt_r <= fail_cnt_n;
            ffo_r      <= ffo_n;
            err_r      <= err_n;
        end
    end

    assign A             = a_r;
    assign B             = b_r;
    assign FuncCode      = func_r;
    assign Opcode        = opc_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign pass          = pass_r;
    assign fail_count    = fail_cnt_r;
    assign first_fail_op = ffo_r;
    assign err_pulse     = err_r;

endmodule

// File: tb/tb_alu_bist_sequencer.sv
// Directed bench for alu_bist_sequencer with a behavioural ALU that can inject faults.
// fault_mode values:
//   0 = correct ALU
//   1 = ALUOut[0] stuck at 0
//   2 = SUB computed as ADD
//   3 = Branch_Enable tied 0
module tb_alu_bist_sequencer;

    localparam int N_ITER = 4;
`ifdef BIST_BRANCH_CHECK_EN
    localparam int N_OPS   = 16;
    localparam int RUN_LEN = 201;
`else
    localparam int N_OPS   = 10;
    localparam int RUN_LEN = 129;
`endif

    logic        clk = 1'b0;
    logic        reset, start;
    logic [31:0] A, B, ALUOut;
    logic [3:0]  FuncCode, first_fail_op;
    logic [6:0]  Opcode;
    logic        Branch_Enable, busy, done, pass, err_pulse;
    logic [15:0] fail_count;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int err_seen  = 0;
    int fault_mode = 0;
    int cyc, exp_cnt, exp_first;

    alu_bist_sequencer #(.NUM_ITER(N_ITER), .SETTLE_CYCLES(2), .LFSR_SEED(32'hACE1_2024)) dut (
        .clk(clk), .reset(reset), .start(start),
        .A(A), .B(B), .FuncCode(FuncCode), .Opcode(Opcode),
        .ALUOut(ALUOut), .Branch_Enable(Branch_Enable),
        .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
        .first_fail_op(first_fail_op), .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    // Behavioural ALU decoding the real opcode/funct fields, with fault injection
    function automatic logic [32:0] alu_model(input int mode, input logic [6:0] opc,
                                              input logic [3:0] fc, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] r;
        logic        be;
        r  = 32'd0;
        be = 1'b0;
        if (opc == 7'b0110011) begin
            case (fc)
                4'b0000: r = a + b;
                4'b1000: r = (mode == 2) ? a + b : a - b;
                4'b0001: r = a << b[4:0];
                4'b0010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                4'b0011: r = (a < b) ? 32'd1 : 32'd0;
                4'b0100: r = a ^ b;
                4'b0101: r = a >> b[4:0];
                4'b1101: r = $signed(a) >>> b[4:0];
                4'b0110: r = a | b;
                4'b0111: r = a & b;
                default: r = 32'd0;
            endcase
        end else if (opc == 7'b1100011) begin
            case (fc[2:0])
                3'b000:  be = (a == b);
                3'b001:  be = (a != b);
                3'b100:  be = ($signed(a) < $signed(b));
                3'b101:  be = ($signed(a) >= $signed(b));
                3'b110:  be = (a < b);
                3'b111:  be = (a >= b);
                default: be = 1'b0;
            endcase
        end
        if (mode == 1) r[0] = 1'b0;
        if (mode == 3) be = 1'b0;
        return {be, r};
    endfunction

    always_comb {Branch_Enable, ALUOut} = alu_model(fault_mode, Opcode, FuncCode, A, B);

    always @(negedge clk) if (err_pulse === 1'b1) err_seen++;

    function automatic logic [10:0] op_entry(input int i);
        case (i)
            0: return {7'b0110011, 4'b0000};  1: return {7'b0110011, 4'b1000};
            2: return {7'b0110011, 4'b0001};  3: return {7'b0110011, 4'b0010};
            4: return {7'b0110011, 4'b0011};  5: return {7'b0110011, 4'b0100};
            6: return {7'b0110011, 4'b0101};  7: return {7'b0110011, 4'b1101};
            8: return {7'b0110011, 4'b0110};  9: return {7'b0110011, 4'b0111};
            10: return {7'b1100011, 4'b0000}; 11: return {7'b1100011, 4'b0001};
            12: return {7'b1100011, 4'b0100}; 13: return {7'b1100011, 4'b0101};
            14: return {7'b1100011, 4'b0110}; 15: return {7'b1100011, 4'b0111};
            default: return 11'd0;
        endcase
    endfunction

    // Expected mismatch count and first failing op for a given fault mode
    task automatic compute_expect(input int mode, output int cnt, output int first);
        logic [31:0] s, a, b;
        logic [32:0] g, f;
        logic [10:0] e;
        s = 32'hACE1_2024;
        cnt = 0;
        first = 15;
        for (int it = 0; it < N_ITER; it++) begin
            a = s; s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
            b = s; s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
            for (int op = 0; op < N_OPS; op++) begin
                e = op_entry(op);
                g = alu_model(0, e[10:4], e[3:0], a, b);
                f = alu_model(mode, e[10:4], e[3:0], a, b);
                if ((op < 10) ? (g[31:0] != f[31:0]) : (g[32] != f[32])) begin
                    cnt++;
                    if (first == 15) first = op;
                end
            end
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, ".A"}, A, 32'd0);
        check_val({tag, ".B"}, B, 32'd0);
        check_val({tag, ".FuncCode"}, {28'd0, FuncCode}, 32'd0);
        check_val({tag, ".Opcode"}, {25'd0, Opcode}, 32'd0);
        check_val({tag, ".busy"}, {31'd0, busy}, 32'd0);
        check_val({tag, ".done"}, {31'd0, done}, 32'd0);
        check_val({tag, ".pass"}, {31'd0, pass}, 32'd0);
        check_val({tag, ".fail_count"}, {16'd0, fail_count}, 32'd0);
        check_val({tag, ".first_fail_op"}, {28'd0, first_fail_op}, 32'hF);
        check_val({tag, ".err_pulse"}, {31'd0, err_pulse}, 32'd0);
    endtask

    // One full run: start pulse, optional start pulses while busy, wait for done
    task automatic run_bist(input string tag, input int extra_start, output int cycles);
        @(negedge clk); #1;
        err_seen = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cycles = 1;
        check_val({tag, ".start_busy"}, {31'd0, busy}, 32'd1);
        check_val({tag, ".start_done_clr"}, {31'd0, done}, 32'd0);
        check_val({tag, ".start_fc_clr"}, {16'd0, fail_count}, 32'd0);
        while (done !== 1'b1 && cycles < 2000) begin
            @(posedge clk); #1;
            cycles++;
            if (cycles == 3) begin
                check_val({tag, ".A0"}, A, 32'hACE1_2024);
                check_val({tag, ".B0"}, B, 32'h5670_9012);
                check_val({tag, ".opc0"}, {25'd0, Opcode}, 32'h33);
            end
            if (extra_start != 0 && cycles == 50) start = 1'b1;
            if (cycles == 52) start = 1'b0;
        end
        check_val({tag, ".done_reached"}, {31'd0, done}, 32'd1);
        check_val({tag, ".run_len"}, cycles, RUN_LEN);
        @(negedge clk); #1;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");
        @(negedge clk);
        reset = 1'b0;

        // Correct ALU
        fault_mode = 0;
        run_bist("good", 0, cyc);
        check_val("good.pass", {31'd0, pass}, 32'd1);
        check_val("good.fail_count", {16'd0, fail_count}, 32'd0);
        check_val("good.ffo", {28'd0, first_fail_op}, 32'hF);
        check_val("good.err_seen", err_seen, 32'd0);
        check_val("good.opc_idle", {25'd0, Opcode}, 32'd0);
        check_val("good.busy_done", {31'd0, busy}, 32'd0);

        // ALUOut[0] stuck at 0: first odd golden result is SLT (A<0, B>0) on iteration 0
        fault_mode = 1;
        compute_expect(1, exp_cnt, exp_first);
        run_bist("stuck", 0, cyc);
        check_val("stuck.pass", {31'd0, pass}, 32'd0);
        check_val("stuck.ffo", {28'd0, first_fail_op}, 32'd3);
        check_val("stuck.ffo_model", {28'd0, first_fail_op}, exp_first);
        check_val("stuck.fail_count", {16'd0, fail_count}, exp_cnt);
        check_val("stuck.err_seen", err_seen, {16'd0, fail_count});

        // SUB computed as ADD; restart from DONE with nonzero fail_count
        fault_mode = 2;
        compute_expect(2, exp_cnt, exp_first);
        run_bist("subadd", 0, cyc);
        check_val("subadd.pass", {31'd0, pass}, 32'd0);
        check_val("subadd.ffo", {28'd0, first_fail_op}, 32'd1);
        check_val("subadd.fail_count", {16'd0, fail_count}, exp_cnt);

        // start pulsed while busy must not disturb the run
        fault_mode = 0;
        run_bist("busystart", 1, cyc);
        check_val("busystart.pass", {31'd0, pass}, 32'd1);

        // Reset during DRIVE of op 5 (XOR), iteration 2
        @(negedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 82) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_val("midrst.func_op5", {28'd0, FuncCode}, 32'b0100);
        check_val("midrst.busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check_reset_vals("midrst");
        @(posedge clk); #1;
        check_val("midrst.hold_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_bist("afterrst", 0, cyc);
        check_val("afterrst.pass", {31'd0, pass}, 32'd1);

`ifdef BIST_BRANCH_CHECK_EN
        // Branch_Enable tied 0: every true branch condition is a mismatch
        fault_mode = 3;
        compute_expect(3, exp_cnt, exp_first);
        run_bist("br0", 0, cyc);
        check_val("br0.fail_count", {16'd0, fail_count}, exp_cnt);
        check_val("br0.err_seen", err_seen, exp_cnt);
        check_val("br0.ffo", {28'd0, first_fail_op}, exp_first);
`endif

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/alu_bist_sequencer.md
Name: alu_bist_sequencer

Overview:
- Hardware self-test initiator for the RV32I execute path.
- Drives Opcode/FuncCode/A/B into the ALU control + ALU pair, then samples ALUOut/Branch_Enable after a settle window.
- Compares each sample against an internal golden model and reports a pass/fail summary.
- Sits beside the execute stage; the ALU inputs are muxed to it during test mode.

Parameters:
- NUM_ITER, 16: operand pairs per run (1..65535).
- SETTLE_CYCLES, 2: cycles each vector is held before sampling (>=1).
- LFSR_SEED, 32'hACE1_2024: operand LFSR seed; must be nonzero.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  run request, sampled in IDLE/DONE only.
- A  out  32  ALU operand A.
- B  out  32  ALU operand B.
- FuncCode  out  4  {funct7[5], funct3} to ALU control.
- Opcode  out  7  opcode to ALU control.
- ALUOut  in  32  ALU result.
- Branch_Enable  in  1  ALU branch flag.
- busy  out  1  run in progress.
- done  out  1  run complete (level).
- pass  out  1  valid with done; 1 when fail_count==0.
- fail_count  out  16  mismatches, saturating at 16'hFFFF.
- first_fail_op  out  4  op index of first mismatch; 4'hF if none.
- err_pulse  out  1  one-cycle pulse per mismatch.

Behaviour:
- Reset values:
  - A, B, FuncCode, Opcode, busy, done, pass, fail_count, err_pulse = 0.
  - first_fail_op = 4'hF.
  - LFSR = LFSR_SEED.
- Reset mid-run aborts immediately to IDLE with all reset values.
- Operand LFSR:
  - 32-bit Galois, mask 32'h8020_0003; advances one step per LOAD cycle.
  - Reloads LFSR_SEED on each accepted start.
- Op table, index: FuncCode, all Opcode 7'b0110011:
  - 0 ADD: 0000
  - 1 SUB: 1000
  - 2 SLL: 0001
  - 3 SLT: 0010
  - 4 SLTU: 0011
  - 5 XOR: 0100
  - 6 SRL: 0101
  - 7 SRA: 1101
  - 8 OR: 0110
  - 9 AND: 0111
- Golden model:
  - Arithmetic is mod 2^32; shifts use B[4:0].
  - SLT is signed, SLTU is unsigned, both producing 32'd0/1.
  - SRA sign-fills.
  - Branch_Enable is not checked for R-type.
- FSM:
  - IDLE: start=1 -> LOAD_A. Clears fail_count and done; busy=1; first_fail_op=F.
  - LOAD_A (1 cycle): A<=lfsr; advance -> LOAD_B.
  - LOAD_B (1 cycle): B<=lfsr; advance; op=0 -> DRIVE.
  - DRIVE: Opcode/FuncCode hold table[op] for SETTLE_CYCLES cycles -> CHECK.
  - CHECK (1 cycle): compare sampled ALUOut with golden.
    - On mismatch: err_pulse=1; fail_count+1 (saturating); first_fail_op<=op if still F.
    - If op<9: op+1 -> DRIVE.
    - Else if iter<NUM_ITER-1: -> LOAD_A.
    - Else -> DONE.
  - DONE: busy=0, done=1, pass=(fail_count==0). start=1 -> behaves as IDLE start (restart).
- start while busy is ignored.
- A/B are stable throughout the 10 ops of an iteration.
- Run length, start-sample edge to done=1: 1 + NUM_ITER*(2 + 10*(SETTLE_CYCLES+1)) cycles.
- Opcode/FuncCode return to 0 in IDLE/DONE.

Optional Feature:
- Macro BIST_BRANCH_CHECK_EN.
- Defined:
  - Op table extends with indices 10..15: BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - These use Opcode 7'b1100011 and FuncCode {0, funct3}: 000, 001, 100, 101, 110, 111.
  - CHECK compares Branch_Enable against the branch condition on A/B; ALUOut is ignored for these.
  - Ops per iteration = 16; run length uses 16 in place of 10.
  - first_fail_op may report 10..14. Index 15 (BGEU) is indistinguishable from "none", accepted limitation.
- Undefined: 10 ops, indices 0..9 only; Branch_Enable is unused.

Test Plan:
- Correct ALU, NUM_ITER=4, SETTLE_CYCLES=2 -> done exactly 129 cycles after start; pass=1; fail_count=0; first_fail_op=F; err_pulse never high.
- ALU model with ALUOut[0] stuck-at-0 -> pass=0; fail_count>=1; first_fail_op equals first op whose golden result is odd; one err_pulse per mismatch.
- ALU model computing SUB as ADD, default seed -> first_fail_op=1 on iteration 0; pass=0.
- reset asserted during DRIVE of op 5, iteration 2 -> next cycle: all outputs at reset values. Re-start gives the same A/B sequence as the first run, from LFSR_SEED.
- start pulsed while busy -> ignored, run length unchanged. start in DONE -> fail_count cleared, new run begins.
- With BIST_BRANCH_CHECK_EN and Branch_Enable tied 0 -> mismatches only where the branch condition is true; fail_count equals the bench-computed count of true conditions.
